hilo_unit: RTL and testbench

HILO_UNIT -- requirements
Module: hilo_unit

---
 rtl/hilo_unit.sv | 197 +++++++++++++++++++
 tb/tb_hilo_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
//   HI/LO multiply-divide unit. A start request captures an operation and two
//   32-bit operands, then runs a fixed 32-iteration radix-2 loop on unsigned
//   magnitudes, followed by a single sign-fixup cycle that loads HI/LO and
//   pulses done. When the unit is idle, HI and LO can also be written directly.
//
// Ports
//   clk    in   1   clock; all state changes on the rising edge
//   rst    in   1   asynchronous reset, active low
//   start  in   1   request a new operation (sampled only while idle)
//   op     in   2   0=MULT, 1=MULTU, 2=DIV, 3=DIVU
//   a      in  32   multiplicand / dividend
//   b      in  32   multiplier / divisor
//   wr_hi  in   1   direct write of hi from wdata (idle, no start)
//   wr_lo  in   1   direct write of lo from wdata (idle, no start)
//   wdata  in  32   direct write data
//   busy   out  1   operation in progress
//   done   out  1   one-cycle pulse; hi/lo already hold the result
//   hi     out 32   product[63:32] or remainder
//   lo     out 32   product[31:0] or quotient
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; direct hi/lo writes allowed
// RUN   | one shift-add / shift-subtract iteration per edge, 32 total
// FIX   | sign correction, hi/lo load, done pulse, back to IDLE
// -----------------------------------------------------------------------------
module hilo_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_q;      // negate product (mult) or quotient (div)
    logic        neg_r;      // remainder takes the dividend's negative sign
    logic [31:0] opnd;       // multiplicand or divisor magnitude
    logic [31:0] acc_hi;     // product upper half / partial remainder
    logic [31:0] acc_lo;     // multiplier bits / dividend bits -> quotient
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        done_r;

    // operand capture
    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        b_zero;

    // iteration datapath
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_diff;

    // sign fixup
    logic [63:0] prod;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[31];
    assign b_neg     = signed_op & b[31];
    assign a_mag     = a_neg ? (32'd0 - a) : a;
    assign b_mag     = b_neg ? (32'd0 - b) : b;
    assign b_zero    = (b == 32'd0);

    // Multiply: add the multiplicand when the current multiplier LSB is set,
    // then shift the 65-bit {carry, acc_hi, acc_lo} right by one.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);

    // Divide: shift the next dividend bit into the remainder and subtract the
    // divisor if it fits. The remainder stays below the divisor, so the
    // shifted value needs 33 bits but a successful difference fits in 32.
    assign div_shift = {acc_hi, acc_lo[31]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_diff  = div_shift[31:0] - opnd;

    // A zero divisor makes the loop produce quotient = all ones and
    // remainder = |a|; neg_q is cleared at capture and neg_r restores the
    // dividend's sign, so hi ends up equal to the raw dividend.
    assign prod      = {acc_hi, acc_lo};
    assign prod_fix  = neg_q ? (64'd0 - prod) : prod;
    assign quo_fix   = neg_q ? (32'd0 - acc_lo) : acc_lo;
    assign rem_fix   = neg_r ? (32'd0 - acc_hi) : acc_hi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN:  if (cnt == 5'd31) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= 5'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            opnd   <= 32'd0;
            acc_hi <= 32'd0;
            acc_lo <= 32'd0;
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt    <= 5'd0;
                        is_div <= op[1];
                        acc_hi <= 32'd0;
                        if (op[1]) begin
                            acc_lo <= a_mag;
                            opnd   <= b_mag;
                            neg_q  <= (a_neg ^ b_neg) & ~b_zero;
                            neg_r  <= a_neg;
                        end else begin
                            acc_lo <= b_mag;
                            opnd   <= a_mag;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= 1'b0;
                        end
                    end else begin
                        if (wr_hi) hi_r <= wdata;
                        if (wr_lo) lo_r <= wdata;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        acc_hi <= div_ge ? div_diff : div_shift[31:0];
                        acc_lo <= {acc_lo[30:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[32:1];
                        acc_lo <= {mul_sum[0], acc_lo[31:1]};
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        hi_r <= rem_fix;
                        lo_r <= quo_fix;
                    end else begin
                        hi_r <= prod_fix[63:32];
                        lo_r <= prod_fix[31:0];
                    end
                    done_r <= 1'b1;
                end
                default: begin
                    cnt <= 5'd0;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_unit
//   Directed and randomized checks of hilo_unit against a reference model
//   built from plain 64-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_hilo_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          tests;
    int          fails;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    hilo_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] x,
                                  input logic [31:0] y,
                                  output logic [31:0] mh, output logic [31:0] ml);
        longint      sx;
        longint      sy;
        logic [63:0] p;
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] q;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        mh = 32'd0;
        ml = 32'd0;
        case (o)
            2'd0: begin
                p  = 64'(sx * sy);
                mh = p[63:32];
                ml = p[31:0];
            end
            2'd1: begin
                p  = ux * uy;
                mh = p[63:32];
                ml = p[31:0];
            end
            default: begin
                if (y == 32'd0) begin
                    mh = x;
                    ml = 32'hFFFF_FFFF;
                end else if (o == 2'd2) begin
                    q  = 64'(sx / sy);
                    r  = 64'(sx % sy);
                    mh = r[31:0];
                    ml = q[31:0];
                end else begin
                    mh = x % y;
                    ml = x / y;
                end
            end
        endcase
    endfunction

    // Drives one start cycle; with_wr also asserts both direct writes to
    // confirm start wins over them.
    task automatic launch(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit with_wr);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (with_wr) begin
            wr_hi = 1'b1;
            wr_lo = 1'b1;
            wdata = 32'hCAFE_F00D;
        end
        tick();
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom_range(0, 3));
    endtask

    // Waits for done, counting cycles from the start edge. An optional
    // injection at cycle 'inject' raises start and both writes for one
    // cycle; none of them may have any effect.
    task automatic finish(input string tag, input logic [31:0] mh,
                          input logic [31:0] ml, input int inject);
        int n;
        int nb;
        bit hold_ok;
        n       = 1;
        nb      = 0;
        hold_ok = 1'b1;
        while (done !== 1'b1 && n < 60) begin
            if (busy === 1'b1) nb++;
            if (hi !== exp_hi || lo !== exp_lo) hold_ok = 1'b0;
            if (n == inject) begin
                start = 1'b1;
                op    = 2'($urandom_range(0, 3));
                a     = $urandom;
                b     = $urandom;
                wr_hi = 1'b1;
                wr_lo = 1'b1;
                wdata = 32'hDEAD_BEEF;
            end else if (n == inject + 1) begin
                start = 1'b0;
                wr_hi = 1'b0;
                wr_lo = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        chk({tag, " latency"}, 32'(n), 32'd34);
        chk({tag, " busy_cycles"}, 32'(nb), 32'd33);
        chk({tag, " hold"}, {31'd0, hold_ok}, 32'd1);
        chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, " hi"}, hi, mh);
        chk({tag, " lo"}, lo, ml);
        exp_hi = mh;
        exp_lo = ml;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input string tag,
                          input int inject, input bit with_wr);
        logic [31:0] mh;
        logic [31:0] ml;
        model(o, x, y, mh, ml);
        launch(o, x, y, with_wr);
        finish(tag, mh, ml, inject);
    endtask

    task automatic direct_wr(input bit h, input bit l, input logic [31:0] d);
        wr_hi = h;
        wr_lo = l;
        wdata = d;
        tick();
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        if (h) exp_hi = d;
        if (l) exp_lo = d;
        chk("wr hi", hi, exp_hi);
        chk("wr lo", lo, exp_lo);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        logic [31:0] mh;
        logic [31:0] ml;
        int          sel;

        tests  = 0;
        fails  = 0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        rst    = 1'b0;
        start  = 1'b0;
        op     = 2'd0;
        a      = 32'd0;
        b      = 32'd0;
        wr_hi  = 1'b0;
        wr_lo  = 1'b0;
        wdata  = 32'd0;

        #3;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // MULTU max x max, then done must drop after one cycle
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 0, 1'b0);
        chk("multu_max hi const", hi, 32'hFFFF_FFFE);
        chk("multu_max lo const", lo, 32'h0000_0001);
        tick();
        chk("done pulse width", {31'd0, done}, 32'd0);
        chk("hi kept after done", hi, 32'hFFFF_FFFE);

        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg", 0, 1'b0);
        chk("mult_neg hi const", hi, 32'hFFFF_FFFF);
        chk("mult_neg lo const", lo, 32'hFFFF_FFEB);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_neg", 0, 1'b0);
        chk("div_neg lo const", lo, 32'hFFFF_FFFD);
        chk("div_neg hi const", hi, 32'hFFFF_FFFF);
        run_op(2'd3, 32'd100, 32'd0, "divu_zero", 0, 1'b0);
        chk("divu_zero lo const", lo, 32'hFFFF_FFFF);
        chk("divu_zero hi const", hi, 32'd100);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0, 1'b0);
        chk("div_ovf lo const", lo, 32'h8000_0000);
        chk("div_ovf hi const", hi, 32'd0);
        run_op(2'd2, 32'hFFFF_FF9C, 32'd0, "div_zero_neg", 0, 1'b0);
        chk("div_zero_neg hi const", hi, 32'hFFFF_FF9C);
        tick();

        // direct writes
        direct_wr(1'b1, 1'b0, 32'h1234_5678);
        chk("mthi const", hi, 32'h1234_5678);
        direct_wr(1'b0, 1'b1, 32'h0BAD_F00D);
        direct_wr(1'b1, 1'b1, 32'h5555_AAAA);

        // start wins over direct writes in the accept cycle; busy-time writes
        // and a start at cycle 10 are ignored; a start in the done cycle
        // is accepted and completes 34 cycles later
        run_op(2'd1, 32'd123456, 32'd654321, "ignore_mid", 10, 1'b1);
        run_op(2'd2, 32'd1000, 32'hFFFF_FFFD, "done_cycle_start", 0, 1'b0);
        tick();

        // reset in the middle of RUN
        direct_wr(1'b1, 1'b1, 32'hA5A5_A5A5);
        launch(2'd1, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        chk("busy before abort", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort hi", hi, 32'd0);
        chk("abort lo", lo, 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("post abort idle", {31'd0, busy}, 32'd0);
        run_op(2'd1, 32'd6, 32'd7, "after_abort", 0, 1'b0);
        chk("after_abort lo const", lo, 32'd42);
        chk("after_abort hi const", hi, 32'd0);

        // randomized operations against the arithmetic model
        for (int k = 0; k < 30; k++) begin
            ro  = 2'($urandom_range(0, 3));
            rx  = $urandom;
            ry  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) ry = 32'd0;
            if (sel == 1) begin
                rx = 32'h8000_0000;
                ry = 32'hFFFF_FFFF;
            end
            if (sel == 2) ry = 32'($urandom_range(1, 15));
            if (sel == 3) rx = 32'h8000_0000;
            model(ro, rx, ry, mh, ml);
            launch(ro, rx, ry, 1'($urandom_range(0, 1)));
            finish("rnd", mh, ml, (sel == 4) ? 20 : 0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
